// File: rtl/display_frame_streamer_pkg.sv
// Shared constants, FSM state type, LFSR step and segment bitmap for display_frame_streamer.
// Segments tile an 8-column grid; each cell leaves a one-pixel gap on its right and bottom edge.
package display_pkg;

    localparam int WIDTH       = 120;
    localparam int HEIGHT      = 52;
    localparam int NB_SEGMENTS = 64;
    localparam int LFSR_W      = 16;
    localparam int PROB_BITS   = 3;
    localparam int FRAME_CNT_W = 8;

    localparam int ROW_W = $clog2(HEIGHT);
    localparam int SEG_W = $clog2(NB_SEGMENTS);
    localparam int WM_W  = WIDTH * HEIGHT;
    localparam int WM_IW = $clog2(WM_W);

    localparam logic [15:0] TAPS_16      = 16'hB400;
    localparam logic [15:0] ZERO_SEED_16 = 16'hACE1;
    localparam logic [LFSR_W-1:0] LFSR_TAPS     = TAPS_16[LFSR_W-1:0];
    localparam logic [LFSR_W-1:0] ZERO_SEED_SUB = ZERO_SEED_16[LFSR_W-1:0];

    localparam int SEG_COLS = 8;
    localparam int SEG_ROWS = NB_SEGMENTS / SEG_COLS;
    localparam int CELL_W   = WIDTH / SEG_COLS;
    localparam int CELL_H   = HEIGHT / SEG_ROWS;
    localparam logic [WIDTH-1:0] CELL_ONES = {{(WIDTH-CELL_W+1){1'b0}}, {(CELL_W-1){1'b1}}};

    typedef enum logic [2:0] {IDLE, SEED, SELECT, STREAM, DONE} state_e;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
    endfunction

    // SEG_ROW_MASK table entry: pixels of segment `seg` lit on row `row`.
    function automatic logic [WIDTH-1:0] seg_row_mask(input int seg, input int row);
        int cx;
        int cy;
        cx = seg % SEG_COLS;
        cy = seg / SEG_COLS;
        if (row >= cy * CELL_H && row < (cy + 1) * CELL_H - 1)
            return CELL_ONES << (cx * CELL_W);
        return '0;
    endfunction

endpackage

// File: rtl/display_frame_streamer_if.sv
// Command and row-stream bundle of display_frame_streamer.
// With DISPLAY_WATERMARK_EN defined the bundle also carries the watmk bitmap.
interface display_frame_streamer_if import display_pkg::*;;

    logic                   start;
    logic [NB_SEGMENTS-1:0] msg;
    logic [LFSR_W-1:0]      seed;
    logic [PROB_BITS-1:0]   prob;
    logic [FRAME_CNT_W-1:0] n_frames;
    logic                   row_ready;
    logic                   row_valid;
    logic [WIDTH-1:0]       row_data;
    logic [ROW_W-1:0]       row_idx;
    logic [FRAME_CNT_W-1:0] frame_idx;
    logic                   busy;
    logic                   done;
`ifdef DISPLAY_WATERMARK_EN
    logic [WM_W-1:0]        watmk;
`endif

    modport master (
        output start, msg, seed, prob, n_frames, row_ready,
`ifdef DISPLAY_WATERMARK_EN
        output watmk,
`endif
        input  row_valid, row_data, row_idx, frame_idx, busy, done
    );

    modport slave (
        input  start, msg, seed, prob, n_frames, row_ready,
`ifdef DISPLAY_WATERMARK_EN
        input  watmk,
`endif
        output row_valid, row_data, row_idx, frame_idx, busy, done
    );

endinterface

// File: rtl/display_seg_rasterizer.sv
// Combinational rasteriser: ORs the bitmap rows of every selected segment for one pixel row.
module display_seg_rasterizer import display_pkg::*; (
    input  logic [NB_SEGMENTS-1:0] selseg,
    input  logic [ROW_W-1:0]       row,
    output logic [WIDTH-1:0]       row_px
);

    logic [NB_SEGMENTS-1:0][WIDTH-1:0] seg_px;

    for (genvar g = 0; g < NB_SEGMENTS; g++) begin : g_seg
        assign seg_px[g] = selseg[g] ? seg_row_mask(g, int'(row)) : '0;
    end

    always_comb begin
        row_px = '0;
        for (int i = 0; i < NB_SEGMENTS; i++) row_px |= seg_px[i];
    end

endmodule

// File: rtl/display_frame_streamer.sv
// Draws per-segment visibility from an LFSR and streams N frames row-by-row over valid/ready.
// Optional DISPLAY_WATERMARK_EN: XOR a latched watmk bitmap into every row.
module display_frame_streamer import display_pkg::*; (
    input  logic                    clk,
    input  logic                    rst_n,
    display_frame_streamer_if.slave bus
);

    state_e                 state_q, state_d;
    logic [LFSR_W-1:0]      lfsr_q, lfsr_d;
    logic [NB_SEGMENTS-1:0] msg_q, msg_d;
    logic [LFSR_W-1:0]      seed_q, seed_d;
    logic [PROB_BITS-1:0]   prob_q, prob_d;
    logic [FRAME_CNT_W-1:0] nf_q, nf_d;
    logic [SEG_W-1:0]       seg_cnt_q, seg_cnt_d;
    logic [NB_SEGMENTS-1:0] selseg_q, selseg_d;
    logic [ROW_W-1:0]       row_q, row_d;
    logic [FRAME_CNT_W-1:0] frame_q, frame_d;
    logic                   row_valid_q, row_valid_d;
    logic [WIDTH-1:0]       row_data_q, row_data_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [WIDTH-1:0]       seg_row;
`ifdef DISPLAY_WATERMARK_EN
    logic [WM_W-1:0]        watmk_q, watmk_d;
    logic [WM_IW-1:0]       wm_base;
`endif

    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        msg_d       = msg_q;
        seed_d      = seed_q;
        prob_d      = prob_q;
        nf_d        = nf_q;
        seg_cnt_d   = seg_cnt_q;
        selseg_d    = selseg_q;
        row_d       = row_q;
        frame_d     = frame_q;
        row_valid_d = row_valid_q;
        done_d      = 1'b0;
`ifdef DISPLAY_WATERMARK_EN
        watmk_d     = watmk_q;
`endif
        unique case (state_q)
            IDLE: begin
                // busy_q still covers the done cycle, so a start there is dropped too
                if (bus.start && !busy_q) begin
                    msg_d    = bus.msg;
                    seed_d   = bus.seed;
                    prob_d   = bus.prob;
                    nf_d     = bus.n_frames;
                    row_d    = '0;
                    frame_d  = '0;
                    selseg_d = '0;
`ifdef DISPLAY_WATERMARK_EN
                    watmk_d  = bus.watmk;
`endif
                    state_d  = (bus.n_frames == '0) ? DONE : SEED;
                end
            end
            SEED: begin
                lfsr_d    = (seed_q == '0) ? ZERO_SEED_SUB : seed_q;
                seg_cnt_d = '0;
                selseg_d  = '0;
                state_d   = SELECT;
            end
            SELECT: begin
                lfsr_d = lfsr_step(lfsr_q);
                selseg_d[seg_cnt_q] = msg_q[seg_cnt_q] & (lfsr_d[PROB_BITS-1:0] < prob_q);
                seg_cnt_d = seg_cnt_q + 1'b1;
                if (seg_cnt_q == SEG_W'(NB_SEGMENTS - 1)) begin
                    row_d       = '0;
                    row_valid_d = 1'b1;
                    state_d     = STREAM;
                end
            end
            STREAM: begin
                if (bus.row_ready) begin
                    if (row_q == ROW_W'(HEIGHT - 1)) begin
                        row_d       = '0;
                        row_valid_d = 1'b0;
                        if (frame_q == nf_q - 1'b1) begin
                            state_d = DONE;
                        end else begin
                            frame_d   = frame_q + 1'b1;
                            seg_cnt_d = '0;
                            selseg_d  = '0;
                            state_d   = SELECT;
                        end
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE) || (state_q == DONE);
    end

    display_seg_rasterizer u_raster (
        .selseg (selseg_d),
        .row    (row_d),
        .row_px (seg_row)
    );

    // While stalled selseg_d/row_d equal their _q values, so the row is recomputed unchanged.
    always_comb begin
        row_data_d = '0;
`ifdef DISPLAY_WATERMARK_EN
        wm_base = WM_IW'(row_d) * WM_IW'(WIDTH);
        if (row_valid_d) row_data_d = seg_row ^ watmk_q[wm_base +: WIDTH];
`else
        if (row_valid_d) row_data_d = seg_row;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lfsr_q      <= '0;
            msg_q       <= '0;
            seed_q      <= '0;
            prob_q      <= '0;
            nf_q        <= '0;
            seg_cnt_q   <= '0;
            selseg_q    <= '0;
            row_q       <= '0;
            frame_q     <= '0;
            row_valid_q <= 1'b0;
            row_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef DISPLAY_WATERMARK_EN
            watmk_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            msg_q       <= msg_d;
            seed_q      <= seed_d;
            prob_q      <= prob_d;
            nf_q        <= nf_d;
            seg_cnt_q   <= seg_cnt_d;
            selseg_q    <= selseg_d;
            row_q       <= row_d;
            frame_q     <= frame_d;
            row_valid_q <= row_valid_d;
            row_data_q  <= row_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef DISPLAY_WATERMARK_EN
            watmk_q     <= watmk_d;
`endif
        end
    end

    assign bus.row_valid = row_valid_q;
    assign bus.row_data  = row_data_q;
    assign bus.row_idx   = row_q;
    assign bus.frame_idx = frame_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_display_frame_streamer.sv
// Randomised bench for display_frame_streamer against a pixel-level reference model.
// Honours DISPLAY_WATERMARK_EN the same way as the design.
module tb_display_frame_streamer;
    import display_pkg::*;

    localparam int GRID = 8;
    localparam int CW   = WIDTH / GRID;
    localparam int CH   = HEIGHT / GRID;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    display_frame_streamer_if bus();
    display_frame_streamer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int vectors = 0;
    int miscompares = 0;
    logic [WIDTH-1:0] exp_data[$], got_data[$];
    int exp_row[$], got_row[$], exp_frame[$], got_frame[$];
    int stall_err;
`ifdef DISPLAY_WATERMARK_EN
    logic [WM_W-1:0] tb_watmk = '0;
`endif

    // Pixel (x,y) is lit when it lies inside a grid cell (not its gap) whose segment is shown.
    function automatic logic [WIDTH-1:0] model_row(input logic [NB_SEGMENTS-1:0] sel, input int y);
        logic [WIDTH-1:0] r = '0;
        for (int x = 0; x < WIDTH; x++)
            if (y < CH * GRID && (y % CH) != CH - 1 && (x % CW) != CW - 1)
                r[x] = sel[(y / CH) * GRID + x / CW];
        return r;
    endfunction

    task automatic build_model(input logic [NB_SEGMENTS-1:0] m, input logic [15:0] s,
                               input int p, input int nf);
        logic [15:0] l;
        logic [NB_SEGMENTS-1:0] sel;
        logic [WIDTH-1:0] d;
        bit lsb;
        exp_data.delete(); exp_row.delete(); exp_frame.delete();
        l = (s == 16'h0) ? 16'hACE1 : s;
        for (int f = 0; f < nf; f++) begin
            for (int i = 0; i < NB_SEGMENTS; i++) begin
                lsb = l[0];
                l = l >> 1;
                if (lsb) l = l ^ 16'hB400;
                sel[i] = m[i] && (int'(l) % (1 << PROB_BITS) < p);
            end
            for (int y = 0; y < HEIGHT; y++) begin
                d = model_row(sel, y);
`ifdef DISPLAY_WATERMARK_EN
                d = d ^ tb_watmk[y * WIDTH +: WIDTH];
`endif
                exp_data.push_back(d); exp_row.push_back(y); exp_frame.push_back(f);
            end
        end
    endtask

    task automatic pulse_start(input logic [NB_SEGMENTS-1:0] m, input logic [15:0] s,
                               input int p, input int nf);
        @(negedge clk);
        bus.msg = m; bus.seed = s; bus.prob = PROB_BITS'(p); bus.n_frames = FRAME_CNT_W'(nf);
`ifdef DISPLAY_WATERMARK_EN
        bus.watmk = tb_watmk;
`endif
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Records accepted beats until done; counts any output change while stalled.
    task automatic collect(input bit rnd_ready, input int max_cyc, output int ndone, output bit tmo);
        logic [WIDTH-1:0] p_data = '0;
        int p_row = 0, p_frame = 0, cyc = 0;
        bit prev_stall = 0, nr;
        got_data.delete(); got_row.delete(); got_frame.delete();
        stall_err = 0; ndone = 0; tmo = 0;
        while (ndone == 0) begin
            @(negedge clk);
            cyc++;
            if (cyc > max_cyc) begin tmo = 1; break; end
            if (prev_stall && (!bus.row_valid || bus.row_data !== p_data ||
                               int'(bus.row_idx) != p_row || int'(bus.frame_idx) != p_frame))
                stall_err++;
            if (bus.done) ndone++;
            nr = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.row_ready = nr;
            if (bus.row_valid && nr) begin
                got_data.push_back(bus.row_data);
                got_row.push_back(int'(bus.row_idx));
                got_frame.push_back(int'(bus.frame_idx));
            end
            prev_stall = bus.row_valid && !nr;
            p_data = bus.row_data; p_row = int'(bus.row_idx); p_frame = int'(bus.frame_idx);
        end
        repeat (4) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.start = 0; bus.msg = '0; bus.seed = '0; bus.prob = '0; bus.n_frames = '0; bus.row_ready = 0;
`ifdef DISPLAY_WATERMARK_EN
        bus.watmk = '0;
`endif
        repeat (3) @(negedge clk);
        vectors++; if (bus.row_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", bus.row_valid); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", bus.done); end
        vectors++; if (bus.row_data !== '0) begin miscompares++; $display("FAIL reset_data: got %h want 0", bus.row_data); end
        vectors++; if ({bus.row_idx, bus.frame_idx} !== '0) begin miscompares++; $display("FAIL reset_idx: got %0d/%0d want 0/0", bus.row_idx, bus.frame_idx); end
        rst_n = 1'b1;
    endtask

    task automatic test_full_prob;
        int nd; bit tmo;
        build_model({NB_SEGMENTS{1'b1}}, 16'h0001, 7, 2);
        pulse_start({NB_SEGMENTS{1'b1}}, 16'h0001, 7, 2);
        collect(0, 2000, nd, tmo);
        vectors++; if (tmo) begin miscompares++; $display("FAIL full_timeout: no done within budget"); end
        vectors++; if (nd != 1) begin miscompares++; $display("FAIL full_done_count: got %0d want 1", nd); end
        vectors++; if (got_data.size() != 104) begin miscompares++; $display("FAIL full_beats: got %0d want 104", got_data.size()); end
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
            vectors++;
            if (got_data[i] !== exp_data[i] || got_row[i] != exp_row[i] || got_frame[i] != exp_frame[i]) begin
                miscompares++;
                $display("FAIL full_beat%0d: got r%0d f%0d %h want r%0d f%0d %h", i, got_row[i], got_frame[i], got_data[i], exp_row[i], exp_frame[i], exp_data[i]);
            end
        end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL full_busy_end: got %b want 0", bus.busy); end
    endtask

    task automatic test_prob_zero;
        int nd; bit tmo; logic [15:0] s;
        s = 16'($urandom);
        build_model({NB_SEGMENTS{1'b1}}, s, 0, 1);
        pulse_start({NB_SEGMENTS{1'b1}}, s, 0, 1);
        collect(0, 1000, nd, tmo);
        vectors++; if (tmo || nd != 1 || got_data.size() != HEIGHT) begin miscompares++; $display("FAIL blank_job: got tmo %0d done %0d beats %0d want 0 1 %0d", tmo, nd, got_data.size(), HEIGHT); end
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
            vectors++;
`ifdef DISPLAY_WATERMARK_EN
            if (got_data[i] !== exp_data[i] || got_row[i] != i) begin
`else
            if (got_data[i] !== '0 || got_row[i] != i) begin
`endif
                miscompares++;
                $display("FAIL blank_row%0d: got r%0d %h want r%0d %h", i, got_row[i], got_data[i], i, exp_data[i]);
            end
        end
    endtask

    task automatic test_empty_job;
        int bad = 0;
        @(negedge clk);
        bus.n_frames = '0; bus.start = 1'b1; bus.row_ready = 1'b1;
        @(negedge clk);
        vectors++; if ({bus.busy, bus.done, bus.row_valid} !== 3'b100) begin miscompares++; $display("FAIL empty_c1: got busy/done/valid %b want 100", {bus.busy, bus.done, bus.row_valid}); end
        // hold start through the busy window with a real job that must be ignored
        bus.n_frames = 8'd5; bus.msg = {NB_SEGMENTS{1'b1}}; bus.prob = 3'd7;
        @(negedge clk);
        vectors++; if ({bus.busy, bus.done, bus.row_valid} !== 3'b110) begin miscompares++; $display("FAIL empty_c2: got busy/done/valid %b want 110", {bus.busy, bus.done, bus.row_valid}); end
        @(negedge clk);
        bus.start = 1'b0;
        vectors++; if ({bus.busy, bus.done, bus.row_valid} !== 3'b000) begin miscompares++; $display("FAIL empty_c3: got busy/done/valid %b want 000", {bus.busy, bus.done, bus.row_valid}); end
        repeat (200) begin
            @(negedge clk);
            if (bus.busy || bus.done || bus.row_valid) bad++;
        end
        vectors++; if (bad != 0) begin miscompares++; $display("FAIL empty_ignored_start: got %0d active cycles want 0", bad); end
    endtask

    task automatic test_stall;
        int nd; bit tmo; logic [NB_SEGMENTS-1:0] m; logic [15:0] s; int p;
        m = {$urandom, $urandom}; s = 16'($urandom); p = $urandom_range(1, 7);
        build_model(m, s, p, 2);
        pulse_start(m, s, p, 2);
        collect(1, 4000, nd, tmo);
        vectors++; if (tmo || nd != 1) begin miscompares++; $display("FAIL stall_done: got tmo %0d done %0d want 0 1", tmo, nd); end
        vectors++; if (stall_err != 0) begin miscompares++; $display("FAIL stall_stable: got %0d unstable cycles want 0", stall_err); end
        vectors++; if (got_data.size() != exp_data.size()) begin miscompares++; $display("FAIL stall_beats: got %0d want %0d", got_data.size(), exp_data.size()); end
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
            vectors++;
            if (got_data[i] !== exp_data[i] || got_row[i] != exp_row[i] || got_frame[i] != exp_frame[i]) begin
                miscompares++;
                $display("FAIL stall_beat%0d: got r%0d f%0d %h want r%0d f%0d %h", i, got_row[i], got_frame[i], got_data[i], exp_row[i], exp_frame[i], exp_data[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int nd; bit tmo; logic [NB_SEGMENTS-1:0] m; logic [15:0] s; int p;
        for (int k = 0; k < 2; k++) begin
            m = {$urandom, $urandom}; s = 16'($urandom); p = $urandom_range(2, 7);
            build_model(m, s, p, 1);
            pulse_start(m, s, p, 1);
            repeat (4) @(negedge clk);
            // start during SELECT with different inputs must leave the job untouched
            pulse_start(~m, s ^ 16'h5A5A, 1, 3);
            collect(0, 1000, nd, tmo);
            vectors++; if (tmo || nd != 1 || got_data.size() != exp_data.size()) begin miscompares++; $display("FAIL b2b%0d_job: got tmo %0d done %0d beats %0d want 0 1 %0d", k, tmo, nd, got_data.size(), exp_data.size()); end
            for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
                vectors++;
                if (got_data[i] !== exp_data[i] || got_row[i] != exp_row[i] || got_frame[i] != exp_frame[i]) begin
                    miscompares++;
                    $display("FAIL b2b%0d_beat%0d: got r%0d %h want r%0d %h", k, i, got_row[i], got_data[i], exp_row[i], exp_data[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_stream;
        int cyc = 0, bad = 0, nd; bit found = 0, tmo; logic [15:0] s;
        s = 16'($urandom);
        pulse_start({NB_SEGMENTS{1'b1}}, s, 7, 3);
        bus.row_ready = 1'b1;
        while (!found && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (bus.row_valid && bus.frame_idx == 8'd1 && bus.row_idx == 6'd10) found = 1;
        end
        vectors++; if (!found) begin miscompares++; $display("FAIL midrst_reach: row 10 frame 1 not seen within %0d cycles", cyc); end
        #2 rst_n = 1'b0;
        #1;
        vectors++; if ({bus.row_valid, bus.busy, bus.done} !== 3'b000 || bus.row_data !== '0 || {bus.row_idx, bus.frame_idx} !== '0) begin
            miscompares++;
            $display("FAIL midrst_outputs: got v%b b%b d%b r%0d f%0d data %h want all 0", bus.row_valid, bus.busy, bus.done, bus.row_idx, bus.frame_idx, bus.row_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (300) begin
            @(negedge clk);
            if (bus.done || bus.row_valid || bus.busy) bad++;
        end
        vectors++; if (bad != 0) begin miscompares++; $display("FAIL midrst_abort: got %0d active cycles want 0", bad); end
        build_model({NB_SEGMENTS{1'b1}}, s, 5, 1);
        pulse_start({NB_SEGMENTS{1'b1}}, s, 5, 1);
        collect(0, 1000, nd, tmo);
        vectors++; if (tmo || nd != 1 || got_data.size() != exp_data.size()) begin miscompares++; $display("FAIL midrst_restart: got tmo %0d done %0d beats %0d want 0 1 %0d", tmo, nd, got_data.size(), exp_data.size()); end
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
            vectors++;
            if (got_data[i] !== exp_data[i] || got_frame[i] != 0) begin
                miscompares++;
                $display("FAIL midrst_beat%0d: got f%0d %h want f0 %h", i, got_frame[i], got_data[i], exp_data[i]);
            end
        end
    endtask

    task automatic test_random_jobs;
        int nd, p, nf; bit tmo; logic [NB_SEGMENTS-1:0] m; logic [15:0] s;
        for (int k = 0; k < 3; k++) begin
            m = {$urandom, $urandom}; s = (k == 0) ? 16'h0 : 16'($urandom);
            p = $urandom_range(0, 7); nf = $urandom_range(1, 2);
            build_model(m, s, p, nf);
            pulse_start(m, s, p, nf);
            collect(k[0], 4000, nd, tmo);
            vectors++; if (tmo || nd != 1 || stall_err != 0 || got_data.size() != exp_data.size()) begin
                miscompares++;
                $display("FAIL rand%0d_job: got tmo %0d done %0d stall %0d beats %0d want 0 1 0 %0d", k, tmo, nd, stall_err, got_data.size(), exp_data.size());
            end
            for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
                vectors++;
                if (got_data[i] !== exp_data[i] || got_row[i] != exp_row[i] || got_frame[i] != exp_frame[i]) begin
                    miscompares++;
                    $display("FAIL rand%0d_beat%0d: got r%0d f%0d %h want r%0d f%0d %h", k, i, got_row[i], got_frame[i], got_data[i], exp_row[i], exp_frame[i], exp_data[i]);
                end
            end
        end
    endtask

`ifdef DISPLAY_WATERMARK_EN
    task automatic test_watermark;
        int nd; bit tmo;
        for (int y = 0; y < HEIGHT; y++)
            for (int x = 0; x < WIDTH; x++)
                tb_watmk[y * WIDTH + x] = 1'((x + y) % 2);
        pulse_start('0, 16'($urandom), 7, 1);
        collect(0, 1000, nd, tmo);
        vectors++; if (tmo || nd != 1 || got_data.size() != HEIGHT) begin miscompares++; $display("FAIL wm_job: got tmo %0d done %0d beats %0d", tmo, nd, got_data.size()); end
        for (int i = 0; i < HEIGHT && i < got_data.size(); i++) begin
            vectors++;
            if (got_data[i] !== tb_watmk[i * WIDTH +: WIDTH]) begin
                miscompares++;
                $display("FAIL wm_row%0d: got %h want %h", i, got_data[i], tb_watmk[i * WIDTH +: WIDTH]);
            end
        end
        tb_watmk = '0;
    endtask
`endif

    initial begin
        test_reset();
        test_full_prob();
        test_prob_zero();
        test_empty_job();
        test_stall();
        test_back_to_back();
        test_reset_mid_stream();
        test_random_jobs();
`ifdef DISPLAY_WATERMARK_EN
        test_watermark();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
